store_buffer: RTL and testbench

//  Committed-store FIFO between the MEM stage and the 4 KB byte-lane data RAM.
//  - Accepts stores via a valid/ready handshake.
//  - Drains at most one entry per cycle onto the RAM write port.
//  - Forwards buffered bytes to loads, so the pipeline never waits on a RAM write.

---
 rtl/store_buffer_if.sv | 41 ++++
 rtl/store_buffer.sv | 105 ++++++++++
 tb/tb_store_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: store request, drain hold, registered RAM write port,
// load-forwarding lookup and occupancy status. master = pipeline side, slave = buffer.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [NB-1:0]     st_sel;
    logic              drain_hold;

    logic              ram_write_enable;
    logic [NB-1:0]     ram_write_select;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] ram_write_data;

    logic [ADDR_W-1:0] ld_addr;
    logic [NB-1:0]     fwd_sel;
    logic [DATA_W-1:0] fwd_data;

    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output st_valid, st_addr, st_data, st_sel, drain_hold, ld_addr,
        input  st_ready, ram_write_enable, ram_write_select, ram_write_addr,
               ram_write_data, fwd_sel, fwd_data, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_sel, drain_hold, ld_addr,
        output st_ready, ram_write_enable, ram_write_select, ram_write_addr,
               ram_write_data, fwd_sel, fwd_data, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO with byte-lane load forwarding; RAM write strobe one cycle after an entry drains.
// Backpressure: st_ready low while full; `STORE_BUF_MERGE_EN lets same-word stores merge into the newest entry.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    logic [WA_W-1:0]   ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [NB-1:0]     ent_sel  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  newest;
    logic [PTR_W-1:0]  idx;
    logic [CNT_W-1:0]  count;
    logic [WA_W-1:0]   st_word;
    logic [WA_W-1:0]   ld_word;
    logic              do_drain;
    logic              do_alloc;
    logic              do_merge;
    logic              merge_hit;

    assign st_word  = bus.st_addr[ADDR_W-1:2];
    assign ld_word  = bus.ld_addr[ADDR_W-1:2];
    assign newest   = tail - PTR_W'(1);
    assign do_drain = (count != '0) && !bus.drain_hold;

`ifdef STORE_BUF_MERGE_EN
    // The newest entry is draining this edge only when it is also the oldest one.
    assign merge_hit = (count != '0) && (ent_addr[newest] == st_word)
                       && !(do_drain && (count == CNT_W'(1)));
`else
    assign merge_hit = 1'b0;
`endif

    assign bus.st_ready = (count != CNT_W'(DEPTH)) || merge_hit;
    assign do_merge     = bus.st_valid && merge_hit;
    assign do_alloc     = bus.st_valid && bus.st_ready && !merge_hit;
    assign bus.empty    = (count == '0);
    assign bus.count    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            bus.ram_write_enable <= 1'b0;
            bus.ram_write_select <= '0;
            bus.ram_write_addr   <= '0;
            bus.ram_write_data   <= '0;
        end else begin
            if (do_alloc) tail <= tail + PTR_W'(1);
            if (do_drain) head <= head + PTR_W'(1);
            count                <= count + CNT_W'(do_alloc) - CNT_W'(do_drain);
            bus.ram_write_enable <= do_drain;
            if (do_drain) begin
                bus.ram_write_select <= ent_sel[head];
                bus.ram_write_addr   <= {ent_addr[head], 2'b00};
                bus.ram_write_data   <= ent_data[head];
            end
        end
    end

    // Entry storage needs no reset: validity is defined purely by head/count.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent_addr[tail] <= st_word;
            ent_data[tail] <= bus.st_data;
            ent_sel[tail]  <= bus.st_sel;
        end else if (do_merge) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.st_sel[b]) ent_data[newest][8*b +: 8] <= bus.st_data[8*b +: 8];
            end
            ent_sel[newest] <= ent_sel[newest] | bus.st_sel;
        end
    end

    // Walk oldest to newest so that a younger matching store overrides older lanes.
    always_comb begin
        bus.fwd_sel  = '0;
        bus.fwd_data = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_addr[idx] == ld_word)) begin
                for (int b = 0; b < NB; b++) begin
                    if (ent_sel[idx][b]) begin
                        bus.fwd_sel[b]          = 1'b1;
                        bus.fwd_data[8*b +: 8]  = ent_data[idx][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand sequences for wrap, reset and merge.
module tb_store_buffer;
`ifdef STORE_BUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        h;
        logic [31:0] la;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_we;
        logic [31:0] e_wa;
        logic [31:0] e_wd;
        logic [3:0]  e_ws;
        logic [3:0]  e_fs;
        logic [31:0] e_fd;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic h, input logic [31:0] la,
                       input logic rdy, input logic [2:0] cnt, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [3:0] fs, input logic [31:0] fd);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.s = s; t.h = h; t.la = la;
        t.e_rdy = rdy; t.e_cnt = cnt; t.e_we = we; t.e_wa = wa; t.e_wd = wd;
        t.e_ws = ws; t.e_fs = fs; t.e_fd = fd;
        vq.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic h, input logic [31:0] la);
        bus.st_valid   = v;
        bus.st_addr    = a;
        bus.st_data    = d;
        bus.st_sel     = s;
        bus.drain_hold = h;
        bus.ld_addr    = la;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          m_cnt;
        bit          m_we;
        bit          acc;
        bit          drn;
        bit          done;
        logic [31:0] exp_q[$];
        logic [31:0] e;

        drive(0, 0, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        @(negedge clk); @(negedge clk);
        #1;
        check("rst count", bus.count, 0);
        check("rst empty", bus.empty, 1);
        check("rst ready", bus.st_ready, 1);
        check("rst we",    bus.ram_write_enable, 0);
        check("rst waddr", bus.ram_write_addr, 0);
        check("rst wdata", bus.ram_write_data, 0);
        check("rst wsel",  bus.ram_write_select, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        // single store latency
        add(1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 32'h100, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h100,                     1, 1, 0, 0, 0, 0, 4'hF, 32'hAABBCCDD);
        add(0, 0, 0, 0, 0, 32'h100,                     1, 0, 1, 32'h100, 32'hAABBCCDD, 4'hF, 4'h0, 32'h0);
        add(0, 0, 0, 0, 0, 0,                           1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        // fill under hold, 5th refused, then full+drain keeps ready low
        add(1, 32'h10, 32'h1, 4'hF, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 32'h14, 32'h2, 4'hF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 32'h18, 32'h3, 4'hF, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(1, 32'h1C, 32'h4, 4'hF, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        add(1, 32'h20, 32'h5, 4'hF, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        add(1, 32'h20, 32'h5, 4'hF, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h10, 32'h1, 4'hF, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 2, 1, 32'h14, 32'h2, 4'hF, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h18, 32'h3, 4'hF, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1C, 32'h4, 4'hF, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // forwarding: newest entry wins per lane, unaligned load address
        add(1, 32'h200, 32'h11223344, 4'b0011, 1, 32'h202, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        add(1, 32'h200, 32'h55667788, 4'b0110, 1, 32'h202, 1, 1, 0, 0, 0, 0, 4'b0011, 32'h00003344);
        add(0, 0, 0, 0, 1, 32'h202, 1, MERGE ? 3'd1 : 3'd2, 0, 0, 0, 0, 4'b0111, 32'h00667744);
        add(0, 0, 0, 0, 0, 32'h202, 1, MERGE ? 3'd1 : 3'd2, 0, 0, 0, 0, 4'b0111, 32'h00667744);
        if (MERGE) begin
            add(0, 0, 0, 0, 0, 32'h202, 1, 0, 1, 32'h200, 32'h11667744, 4'b0111, 4'h0, 32'h0);
            add(0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        end else begin
            add(0, 0, 0, 0, 0, 32'h202, 1, 1, 1, 32'h200, 32'h11223344, 4'b0011, 4'b0110, 32'h00667700);
            add(0, 0, 0, 0, 0, 0,       1, 0, 1, 32'h200, 32'h55667788, 4'b0110, 4'h0, 32'h0);
        end
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // sel == 0 store drains as a no-byte write
        add(1, 32'h500, 32'h12345678, 4'h0, 0, 32'h500, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h500, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h500, 1, 0, 1, 32'h500, 32'h12345678, 4'h0, 4'h0, 32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].v, vq[i].a, vq[i].d, vq[i].s, vq[i].h, vq[i].la);
            #1;
            check($sformatf("v%0d ready", i), bus.st_ready, vq[i].e_rdy);
            check($sformatf("v%0d count", i), bus.count, vq[i].e_cnt);
            check($sformatf("v%0d we", i),    bus.ram_write_enable, vq[i].e_we);
            if (vq[i].e_we) begin
                check($sformatf("v%0d waddr", i), bus.ram_write_addr, vq[i].e_wa);
                check($sformatf("v%0d wdata", i), bus.ram_write_data, vq[i].e_wd);
                check($sformatf("v%0d wsel", i),  bus.ram_write_select, vq[i].e_ws);
            end
            check($sformatf("v%0d fwd_sel", i),  bus.fwd_sel, vq[i].e_fs);
            check($sformatf("v%0d fwd_data", i), bus.fwd_data, vq[i].e_fd);
        end

        // ---------------- 8 stores through 4 entries: wrap, enqueue+drain ----------------
        k = 0; m_cnt = 0; m_we = 0; done = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            drive(k < 8, 32'h400 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, k < 4, 0);
            #1;
            check("wrap count", bus.count, 32'(m_cnt));
            check("wrap ready", bus.st_ready, (m_cnt != 4) ? 1 : 0);
            check("wrap we", bus.ram_write_enable, m_we);
            if (bus.ram_write_enable) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wrap extra strobe: got addr 0x%0h, expected no write", bus.ram_write_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wrap order addr", bus.ram_write_addr, 32'h400 + 32'(4 * e));
                    check("wrap order data", bus.ram_write_data, 32'hC0DE0000 + e);
                end
            end
            acc = bus.st_valid && (m_cnt != 4);
            drn = (m_cnt != 0) && !bus.drain_hold;
            if (acc) begin
                exp_q.push_back(32'(k));
                k++;
            end
            m_cnt = m_cnt + int'(acc) - int'(drn);
            m_we  = drn;
            done  = (k == 8) && (m_cnt == 0) && !m_we;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL wrap timeout: got %0d stores accepted, expected 8 drained", k);
        end
        check("wrap all drained", exp_q.size(), 0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 4'hF, 1, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("pre-rst we", bus.ram_write_enable, 1);
        check("pre-rst count", bus.count, 2);
        #1 rst = 1'b1;
        #1;
        check("async rst we", bus.ram_write_enable, 0);
        check("async rst count", bus.count, 0);
        check("async rst wsel", bus.ram_write_select, 0);
        check("async rst waddr", bus.ram_write_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post-rst no strobe", bus.ram_write_enable, 0);
            check("post-rst count", bus.count, 0);
        end

`ifdef STORE_BUF_MERGE_EN
        // ---------------- merge into newest entry ----------------
        @(negedge clk);
        drive(1, 32'h300, 32'h000000AA, 4'b0001, 1, 0);
        @(negedge clk);
        drive(1, 32'h300, 32'h0000BB00, 4'b0010, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h300);
        #1;
        check("merge count", bus.count, 1);
        check("merge fwd_sel", bus.fwd_sel, 4'b0011);
        check("merge fwd_data", bus.fwd_data, 32'h0000BBAA);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("merge we", bus.ram_write_enable, 1);
        check("merge waddr", bus.ram_write_addr, 32'h300);
        check("merge wsel", bus.ram_write_select, 4'b0011);
        check("merge wdata", bus.ram_write_data, 32'h0000BBAA);
        @(negedge clk);
        #1;
        check("merge single strobe", bus.ram_write_enable, 0);
        check("merge final count", bus.count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
